// File: rtl/types_pkg.sv
// Shared rename/dispatch types and opcode constants for the dispatch stage.
package types_pkg;

    localparam int TP_PREG_W = 7;
    localparam int TP_ROB_W  = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0]          pc;
        logic [6:0]           opcode;
        logic [TP_PREG_W-1:0] ps1;
        logic [TP_PREG_W-1:0] ps2;
        logic [TP_PREG_W-1:0] pd_new;
        logic [TP_PREG_W-1:0] pd_old;
    } rename_data;

    typedef struct packed {
        logic [31:0]          pc;
        logic [6:0]           opcode;
        logic [TP_PREG_W-1:0] ps1;
        logic                 pr1_ready;
        logic [TP_PREG_W-1:0] ps2;
        logic                 pr2_ready;
        logic [TP_PREG_W-1:0] pd_new;
        logic [TP_PREG_W-1:0] pd_old;
        logic [TP_ROB_W-1:0]  rob_index;
    } dispatch_pipeline_data;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/dispatch_queue.sv
// Per-class dispatch FIFO of renamed instructions; head is read combinationally
// so the arbiter can dispatch it in the same cycle it is selected.
module dispatch_queue
    import types_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  rename_data                  i_data,
    output rename_data                  o_head,
    output logic [$clog2(QDEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    rename_data       r_mem [QDEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_push = i_push && !i_flush && (r_count != CNT_W'(QDEPTH));
    assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= ptr_inc(r_tail);
            if (w_do_pop)  r_head <= ptr_inc(r_head);
            // simultaneous push and pop leaves the occupancy unchanged
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // storage carries no reset so it maps onto plain memory
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= i_data;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/dispatch_arb.sv
// Dispatch stage: per-class queues feeding RS/ROB through one grant per cycle.
// Define DISPATCH_RR_EN for round-robin arbitration; otherwise lowest class wins.
module dispatch_arb
    import types_pkg::*;
#(
    parameter int NUM_CLASS = 3,
    parameter int QDEPTH    = 2,
    parameter int NUM_CDB   = 3,
    parameter int PREG_W    = TP_PREG_W,
    parameter int ROB_W     = TP_ROB_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    input  rename_data                        data_in,
    input  logic [NUM_CLASS-1:0]              fu_class_in,
    output logic                              ready_in,
    output logic [NUM_CLASS-1:0]              rs_valid_out,
    output dispatch_pipeline_data             rs_data_out,
    input  logic [NUM_CLASS-1:0]              rs_ready_in,
    output logic                              nr_valid_out,
    output logic [PREG_W-1:0]                 nr_reg_out,
    output logic [PREG_W-1:0]                 query_ps1,
    output logic [PREG_W-1:0]                 query_ps2,
    input  logic                              pr1_is_ready,
    input  logic                              pr2_is_ready,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic [NUM_CDB-1:0][PREG_W-1:0]    cdb_tag,
    output logic                              rob_we_out,
    output logic [PREG_W-1:0]                 rob_pd_new_out,
    output logic [PREG_W-1:0]                 rob_pd_old_out,
    output logic [31:0]                       rob_pc_out,
    input  logic [ROB_W-1:0]                  rob_tag_in,
    input  logic                              rob_full_in,
    output logic                              lsq_alloc_valid_out,
    output logic [ROB_W-1:0]                  lsq_dispatch_rob_tag,
    input  logic                              mispredict
);

    localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    rename_data             w_head  [NUM_CLASS];
    logic [CNT_W-1:0]       w_count [NUM_CLASS];
    logic [NUM_CLASS-1:0]   w_full;
    logic [NUM_CLASS-1:0]   w_push;
    logic [NUM_CLASS-1:0]   w_eligible;
    logic [NUM_CLASS-1:0]   w_grant_vec;
    logic                   w_grant;
    logic [CLS_W-1:0]       w_grant_idx;
    logic                   w_accept;
    rename_data             w_sel;
    logic                   w_pr1_ready;
    logic                   w_pr2_ready;

    // fullness is judged on the current count; a same-cycle pop does not help
    assign ready_in = !mispredict && ((fu_class_in & w_full) == '0);
    assign w_accept = valid_in && ready_in && (|fu_class_in);

    generate
        for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_class
            assign w_full[gi]     = (w_count[gi] == CNT_W'(QDEPTH));
            assign w_push[gi]     = w_accept && fu_class_in[gi];
            assign w_eligible[gi] = (w_count[gi] != '0) && rs_ready_in[gi]
                                    && !rob_full_in && !mispredict;

            dispatch_queue #(.QDEPTH(QDEPTH)) u_queue (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_push[gi]),
                .i_pop   (w_grant_vec[gi]),
                .i_flush (mispredict),
                .i_data  (data_in),
                .o_head  (w_head[gi]),
                .o_count (w_count[gi])
            );
        end
    endgenerate

`ifdef DISPATCH_RR_EN
    logic [CLS_W-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_grant_idx == CLS_W'(NUM_CLASS - 1)) ? '0 : w_grant_idx + CLS_W'(1);
        end
    end

    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            int idx;
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_CLASS) idx = idx - NUM_CLASS;
            if (!w_grant && w_eligible[idx]) begin
                w_grant     = 1'b1;
                w_grant_idx = CLS_W'(idx);
            end
        end
    end
`else
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        // scanning downward leaves the lowest eligible index as the winner
        for (int i = NUM_CLASS - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant     = 1'b1;
                w_grant_idx = CLS_W'(i);
            end
        end
    end
`endif

    assign w_grant_vec = w_grant ? (NUM_CLASS'(1) << w_grant_idx) : '0;
    assign w_sel       = w_head[w_grant_idx];

    // a source is ready if it is x0, already written, or broadcast this cycle
    always_comb begin
        w_pr1_ready = (w_sel.ps1 == '0) || pr1_is_ready;
        w_pr2_ready = (w_sel.ps2 == '0) || pr2_is_ready;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (cdb_valid[i] && (cdb_tag[i] == w_sel.ps1)) w_pr1_ready = 1'b1;
            if (cdb_valid[i] && (cdb_tag[i] == w_sel.ps2)) w_pr2_ready = 1'b1;
        end
    end

    always_comb begin
        rs_valid_out         = w_grant_vec;
        rs_data_out          = '0;
        rob_we_out           = 1'b0;
        rob_pd_new_out       = '0;
        rob_pd_old_out       = '0;
        rob_pc_out           = '0;
        query_ps1            = '0;
        query_ps2            = '0;
        lsq_alloc_valid_out  = 1'b0;
        lsq_dispatch_rob_tag = '0;
        if (w_grant) begin
            rs_data_out.pc        = w_sel.pc;
            rs_data_out.opcode    = w_sel.opcode;
            rs_data_out.ps1       = w_sel.ps1;
            rs_data_out.pr1_ready = w_pr1_ready;
            rs_data_out.ps2       = w_sel.ps2;
            rs_data_out.pr2_ready = w_pr2_ready;
            rs_data_out.pd_new    = w_sel.pd_new;
            rs_data_out.pd_old    = w_sel.pd_old;
            rs_data_out.rob_index = rob_tag_in;
            rob_we_out            = 1'b1;
            rob_pd_new_out        = w_sel.pd_new;
            rob_pd_old_out        = w_sel.pd_old;
            rob_pc_out            = w_sel.pc;
            query_ps1             = w_sel.ps1;
            query_ps2             = w_sel.ps2;
            if (is_mem_op(w_sel.opcode)) begin
                lsq_alloc_valid_out  = 1'b1;
                lsq_dispatch_rob_tag = rob_tag_in;
            end
        end
    end

    assign nr_valid_out = w_accept && (data_in.pd_new != '0);
    assign nr_reg_out   = nr_valid_out ? data_in.pd_new : '0;

endmodule

// File: tb/tb_dispatch_arb.sv
// Directed bench for dispatch_arb with a per-class scoreboard of accepted ops.
module tb_dispatch_arb;
    import types_pkg::*;

    localparam int NUM_CLASS = 3;
    localparam int QDEPTH    = 2;
    localparam int NUM_CDB   = 3;
    localparam int PREG_W    = TP_PREG_W;
    localparam int ROB_W     = TP_ROB_W;
    localparam logic [6:0] OPC_ALU = 7'b0110011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    logic                           clk;
    logic                           reset;
    logic                           valid_in;
    rename_data                     data_in;
    logic [NUM_CLASS-1:0]           fu_class_in;
    logic                           ready_in;
    logic [NUM_CLASS-1:0]           rs_valid_out;
    dispatch_pipeline_data          rs_data_out;
    logic [NUM_CLASS-1:0]           rs_ready_in;
    logic                           nr_valid_out;
    logic [PREG_W-1:0]              nr_reg_out;
    logic [PREG_W-1:0]              query_ps1;
    logic [PREG_W-1:0]              query_ps2;
    logic                           pr1_is_ready;
    logic                           pr2_is_ready;
    logic [NUM_CDB-1:0]             cdb_valid;
    logic [NUM_CDB-1:0][PREG_W-1:0] cdb_tag;
    logic                           rob_we_out;
    logic [PREG_W-1:0]              rob_pd_new_out;
    logic [PREG_W-1:0]              rob_pd_old_out;
    logic [31:0]                    rob_pc_out;
    logic [ROB_W-1:0]               rob_tag_in;
    logic                           rob_full_in;
    logic                           lsq_alloc_valid_out;
    logic [ROB_W-1:0]               lsq_dispatch_rob_tag;
    logic                           mispredict;

    dispatch_arb #(
        .NUM_CLASS(NUM_CLASS), .QDEPTH(QDEPTH), .NUM_CDB(NUM_CDB),
        .PREG_W(PREG_W), .ROB_W(ROB_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .fu_class_in(fu_class_in), .ready_in(ready_in),
        .rs_valid_out(rs_valid_out), .rs_data_out(rs_data_out),
        .rs_ready_in(rs_ready_in), .nr_valid_out(nr_valid_out),
        .nr_reg_out(nr_reg_out), .query_ps1(query_ps1), .query_ps2(query_ps2),
        .pr1_is_ready(pr1_is_ready), .pr2_is_ready(pr2_is_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rob_we_out(rob_we_out),
        .rob_pd_new_out(rob_pd_new_out), .rob_pd_old_out(rob_pd_old_out),
        .rob_pc_out(rob_pc_out), .rob_tag_in(rob_tag_in),
        .rob_full_in(rob_full_in), .lsq_alloc_valid_out(lsq_alloc_valid_out),
        .lsq_dispatch_rob_tag(lsq_dispatch_rob_tag), .mispredict(mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cls;
        rename_data d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ord [6];
    int   ord2 [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        valid_in    = 1'b0;
        fu_class_in = '0;
        data_in     = '0;
    endtask

    // record=1 when the op is expected to be dispatched later
    task automatic send(input int cls, input logic [6:0] opc, input logic [6:0] ps1,
                        input logic [6:0] ps2, input logic [6:0] pd_new,
                        input logic [6:0] pd_old, input logic [31:0] pc, input bit record);
        rename_data r;
        exp_t       e;
        r.pc = pc; r.opcode = opc; r.ps1 = ps1; r.ps2 = ps2;
        r.pd_new = pd_new; r.pd_old = pd_old;
        data_in     = r;
        fu_class_in = NUM_CLASS'(1) << cls;
        valid_in    = 1'b1;
        if (record) begin
            e.cls = cls;
            e.d   = r;
            sb.push_back(e);
        end
        $display("drive class=%0d pd_new=%0d pc=%0h record=%0d", cls, pd_new, pc, record);
    endtask

    task automatic no_grant(input string tag);
        chk({tag, "_rs_valid"}, 64'(rs_valid_out), 64'd0);
        chk({tag, "_rob_we"}, 64'(rob_we_out), 64'd0);
        chk({tag, "_lsq"}, 64'(lsq_alloc_valid_out), 64'd0);
    endtask

    task automatic check_grant(input int cls);
        int   found;
        exp_t e;
        logic exp_pr1;
        logic exp_pr2;
        logic exp_mem;
        chk("grant_vec", 64'(rs_valid_out), 64'(NUM_CLASS'(1) << cls));
        chk("rob_we", 64'(rob_we_out), 64'd1);
        found = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (found < 0 && sb[i].cls == cls) found = i;
        end
        n_cmp++;
        assert (found >= 0) else begin
            n_err++;
            $error("FAIL sb_lookup observed=grant class %0d expected=queued entry", cls);
        end
        if (found >= 0) begin
            e = sb[found];
            sb.delete(found);
            exp_pr1 = (e.d.ps1 == '0) || pr1_is_ready;
            exp_pr2 = (e.d.ps2 == '0) || pr2_is_ready;
            for (int i = 0; i < NUM_CDB; i++) begin
                if (cdb_valid[i] && cdb_tag[i] == e.d.ps1) exp_pr1 = 1'b1;
                if (cdb_valid[i] && cdb_tag[i] == e.d.ps2) exp_pr2 = 1'b1;
            end
            exp_mem = (e.d.opcode == 7'b0000011) || (e.d.opcode == 7'b0100011);
            chk("rs_pd_new", 64'(rs_data_out.pd_new), 64'(e.d.pd_new));
            chk("rs_pc", 64'(rs_data_out.pc), 64'(e.d.pc));
            chk("rs_ps1", 64'(rs_data_out.ps1), 64'(e.d.ps1));
            chk("rob_pd_new", 64'(rob_pd_new_out), 64'(e.d.pd_new));
            chk("rob_pd_old", 64'(rob_pd_old_out), 64'(e.d.pd_old));
            chk("rob_pc", 64'(rob_pc_out), 64'(e.d.pc));
            chk("query_ps1", 64'(query_ps1), 64'(e.d.ps1));
            chk("query_ps2", 64'(query_ps2), 64'(e.d.ps2));
            chk("rob_index", 64'(rs_data_out.rob_index), 64'(rob_tag_in));
            chk("pr1_ready", 64'(rs_data_out.pr1_ready), 64'(exp_pr1));
            chk("pr2_ready", 64'(rs_data_out.pr2_ready), 64'(exp_pr2));
            chk("lsq_valid", 64'(lsq_alloc_valid_out), 64'(exp_mem));
            chk("lsq_tag", 64'(lsq_dispatch_rob_tag), exp_mem ? 64'(rob_tag_in) : 64'd0);
            $display("grant class=%0d pd_new=%0d pc=%0h rob_tag=%0d", cls, e.d.pd_new, e.d.pc, rob_tag_in);
        end
    endtask

    initial begin
`ifdef DISPATCH_RR_EN
        ord  = '{1, 2, 0, 1, 2, 0};
        ord2 = '{1, 0};
`else
        ord  = '{0, 0, 1, 1, 2, 2};
        ord2 = '{0, 1};
`endif
        reset = 1'b1; mispredict = 1'b0; rob_full_in = 1'b0; rob_tag_in = '0;
        rs_ready_in = '1; pr1_is_ready = 1'b0; pr2_is_ready = 1'b0;
        cdb_valid = '0; cdb_tag = '0;
        idle();
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("reset_ready", 64'(ready_in), 64'd1);
        chk("reset_nr", 64'(nr_valid_out), 64'd0);
        chk("reset_rs_data", 64'(rs_data_out), 64'd0);
        no_grant("reset");
        tick();

        // ALU op accepted, dispatched one cycle later
        rob_tag_in = 5'd5;
        send(0, OPC_ALU, 7'd3, 7'd0, 7'd12, 7'd2, 32'h100, 1'b1);
        settle();
        chk("acc_ready", 64'(ready_in), 64'd1);
        chk("acc_nr_valid", 64'(nr_valid_out), 64'd1);
        chk("acc_nr_reg", 64'(nr_reg_out), 64'd12);
        no_grant("no_bypass");
        tick();
        idle();
        settle();
        check_grant(0);
        tick();

        // fill BR queue while its RS is blocked
        rs_ready_in = 3'b101;
        send(1, OPC_BR, 7'd5, 7'd6, 7'd20, 7'd1, 32'h200, 1'b1);
        settle();
        chk("br1_ready", 64'(ready_in), 64'd1);
        no_grant("br_blocked");
        tick();
        send(1, OPC_BR, 7'd5, 7'd6, 7'd21, 7'd1, 32'h204, 1'b1);
        settle();
        chk("br2_ready", 64'(ready_in), 64'd1);
        tick();
        send(1, OPC_BR, 7'd5, 7'd6, 7'd22, 7'd1, 32'h208, 1'b0);
        settle();
        chk("br_full_ready", 64'(ready_in), 64'd0);
        chk("br_full_nr", 64'(nr_valid_out), 64'd0);
        send(0, OPC_ALU, 7'd3, 7'd4, 7'd13, 7'd2, 32'h300, 1'b1);
        settle();
        chk("alu_while_br_full", 64'(ready_in), 64'd1);
        no_grant("alu_empty");
        tick();
        idle();
        settle();
        check_grant(0);
        tick();

        // load every queue with all RS blocked
        rs_ready_in = 3'b000;
        send(0, OPC_ALU, 7'd8, 7'd9, 7'd14, 7'd3, 32'h400, 1'b1);
        settle();
        no_grant("fill_blocked");
        tick();
        send(0, OPC_ALU, 7'd8, 7'd9, 7'd15, 7'd3, 32'h404, 1'b1);
        tick();
        send(2, OPC_STORE, 7'd20, 7'd0, 7'd0, 7'd0, 32'h500, 1'b1);
        settle();
        chk("store_ready", 64'(ready_in), 64'd1);
        chk("store_nr_valid", 64'(nr_valid_out), 64'd0);
        tick();
        send(2, OPC_LOAD, 7'd10, 7'd0, 7'd32, 7'd7, 32'h504, 1'b1);
        tick();

        // ROB full stalls all grants
        idle();
        rs_ready_in = 3'b111;
        rob_full_in = 1'b1;
        cdb_valid   = 3'b100;
        cdb_tag[2]  = 7'd20;
        settle();
        no_grant("rob_full");
        tick();

        rob_full_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rob_tag_in   = ROB_W'(9 + k);
            pr1_is_ready = (k == 5);
            settle();
            check_grant(ord[k]);
            tick();
        end
        pr1_is_ready = 1'b0;
        cdb_valid = '0;
        settle();
        no_grant("drained");
        tick();

        // mispredict flushes queued work and blocks the incoming op
        rs_ready_in = 3'b000;
        send(0, OPC_ALU, 7'd1, 7'd1, 7'd40, 7'd1, 32'h600, 1'b0);
        tick();
        send(1, OPC_BR, 7'd1, 7'd1, 7'd41, 7'd1, 32'h604, 1'b0);
        tick();
        mispredict = 1'b1;
        rs_ready_in = 3'b111;
        send(0, OPC_ALU, 7'd1, 7'd1, 7'd42, 7'd1, 32'h608, 1'b0);
        settle();
        chk("mp_ready", 64'(ready_in), 64'd0);
        chk("mp_nr_valid", 64'(nr_valid_out), 64'd0);
        no_grant("mp");
        tick();
        mispredict = 1'b0;
        valid_in = 1'b0;
        fu_class_in = 3'b010;
        settle();
        chk("post_mp_ready", 64'(ready_in), 64'd1);
        no_grant("post_mp_empty");
        tick();

        // arbitration pointer survives the flush
        rs_ready_in = 3'b000;
        send(0, OPC_ALU, 7'd2, 7'd0, 7'd50, 7'd4, 32'h700, 1'b1);
        tick();
        send(1, OPC_BR, 7'd2, 7'd0, 7'd51, 7'd4, 32'h704, 1'b1);
        tick();
        idle();
        rs_ready_in = 3'b111;
        for (int k = 0; k < 2; k++) begin
            rob_tag_in = ROB_W'(20 + k);
            settle();
            check_grant(ord2[k]);
            tick();
        end

        // reset mid-operation empties queues and restarts arbitration at class 0
        rs_ready_in = 3'b000;
        send(2, OPC_LOAD, 7'd2, 7'd0, 7'd60, 7'd4, 32'h800, 1'b0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rs_ready_in = 3'b111;
        settle();
        no_grant("post_reset");
        tick();
        rs_ready_in = 3'b000;
        send(1, OPC_BR, 7'd2, 7'd0, 7'd61, 7'd4, 32'h900, 1'b1);
        tick();
        send(0, OPC_ALU, 7'd2, 7'd0, 7'd62, 7'd4, 32'h904, 1'b1);
        tick();
        idle();
        rs_ready_in = 3'b111;
        for (int k = 0; k < 2; k++) begin
            rob_tag_in = ROB_W'(24 + k);
            settle();
            check_grant(k);
            tick();
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
